// File: rtl/peak_finder_mc_if.sv
// Sample/result bundle for peak_finder_mc: sample input side, result
// handshake and status. The master modport is the upstream/downstream side.
interface peak_finder_mc_if #(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 4,
   parameter int IDX_W  = 8
);
   logic                       en;
   logic [1:0]                 mode;
   logic                       in_valid;
   logic [NUM_CH*DATA_W-1:0]   data_in;
   logic                       out_valid;
   logic                       out_ready;
   logic [NUM_CH*DATA_W-1:0]   peak_value;
   logic [NUM_CH*IDX_W-1:0]    peak_idx;
   logic                       overrun;

   modport master (
      output en, mode, in_valid, data_in, out_ready,
      input  out_valid, peak_value, peak_idx, overrun
   );

   modport slave (
      input  en, mode, in_valid, data_in, out_ready,
      output out_valid, peak_value, peak_idx, overrun
   );
endinterface

// File: rtl/peak_finder_mc.sv
// Multi-channel epoch peak detector (abs/max/min) with valid/ready result output.
// Optional macro PEAK_IDX_EN builds per-channel peak index tracking.
module peak_finder_mc #(
   parameter int DATA_W       = 32,
   parameter int NUM_CH       = 4,
   parameter int EPOCH_LENGTH = 256,
   parameter int IDX_W        = $clog2(EPOCH_LENGTH)
) (
   input logic             clk,
   input logic             rst,
   peak_finder_mc_if.slave io
);
   localparam logic signed [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [IDX_W-1:0]         LAST    = IDX_W'(EPOCH_LENGTH - 1);

   typedef enum logic [1:0] {
      M_ABS = 2'b00,
      M_MAX = 2'b01,
      M_MIN = 2'b10,
      M_RSV = 2'b11
   } mode_t;

   logic [IDX_W-1:0]         cnt;
   mode_t                    mode_q;
   mode_t                    mode_cur;
   logic                     accept;
   logic                     first;
   logic                     done;
   logic                     out_valid_q;
   logic                     overrun_q;

   logic signed [DATA_W-1:0] samp    [NUM_CH];
   logic signed [DATA_W-1:0] metric  [NUM_CH];
   logic signed [DATA_W-1:0] run_val [NUM_CH];
   logic signed [DATA_W-1:0] nxt_val [NUM_CH];
   logic signed [DATA_W-1:0] res_val [NUM_CH];
   logic                     better  [NUM_CH];

   assign accept   = io.en && io.in_valid;
   assign first    = (cnt == '0);
   assign done     = accept && (cnt == LAST);
   // mode is sampled on the first sample so it applies to that sample too
   assign mode_cur = first ? mode_t'(io.mode) : mode_q;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         samp[c] = $signed(io.data_in[c*DATA_W +: DATA_W]);
         if (mode_cur == M_MAX || mode_cur == M_MIN)
            metric[c] = samp[c];
         else if (samp[c] == MIN_NEG)
            metric[c] = MAX_POS;
         else if (samp[c][DATA_W-1])
            metric[c] = -samp[c];
         else
            metric[c] = samp[c];
         better[c]  = (mode_cur == M_MIN) ? (metric[c] < run_val[c])
                                          : (metric[c] > run_val[c]);
         nxt_val[c] = (first || better[c]) ? metric[c] : run_val[c];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         mode_q      <= M_ABS;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            run_val[c] <= '0;
            res_val[c] <= '0;
         end
      end else begin
         if (!io.en) begin
            cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) run_val[c] <= '0;
         end else if (io.in_valid) begin
            if (first) mode_q <= mode_cur;
            cnt <= done ? '0 : cnt + IDX_W'(1);
            for (int c = 0; c < NUM_CH; c++) run_val[c] <= nxt_val[c];
         end
         // a completing epoch always wins over the consumer's accept
         if (done) begin
            out_valid_q <= 1'b1;
            for (int c = 0; c < NUM_CH; c++) res_val[c] <= nxt_val[c];
            if (out_valid_q && !io.out_ready) overrun_q <= 1'b1;
         end else if (out_valid_q && io.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign io.out_valid = out_valid_q;
   assign io.overrun   = overrun_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_val
      assign io.peak_value[c*DATA_W +: DATA_W] = res_val[c];
   end

`ifdef PEAK_IDX_EN
   logic [IDX_W-1:0] run_idx [NUM_CH];
   logic [IDX_W-1:0] nxt_idx [NUM_CH];
   logic [IDX_W-1:0] res_idx [NUM_CH];

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (first)          nxt_idx[c] = '0;
         else if (better[c]) nxt_idx[c] = cnt;
         else                nxt_idx[c] = run_idx[c];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            run_idx[c] <= '0;
            res_idx[c] <= '0;
         end
      end else begin
         if (!io.en) begin
            for (int c = 0; c < NUM_CH; c++) run_idx[c] <= '0;
         end else if (io.in_valid) begin
            for (int c = 0; c < NUM_CH; c++) run_idx[c] <= nxt_idx[c];
         end
         if (done) begin
            for (int c = 0; c < NUM_CH; c++) res_idx[c] <= nxt_idx[c];
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_idx
      assign io.peak_idx[c*IDX_W +: IDX_W] = res_idx[c];
   end
`else
   assign io.peak_idx = '0;
`endif
endmodule

// File: tb/tb_peak_finder_mc.sv
// Directed bench for peak_finder_mc: 2 channels, 32-bit samples, 8-sample epochs.
module tb_peak_finder_mc;
   localparam int DW = 32;
   localparam int NC = 2;
   localparam int EL = 8;
   localparam int IW = 3;
`ifdef PEAK_IDX_EN
   localparam bit IDX_ON = 1'b1;
`else
   localparam bit IDX_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] s0 [8];
   logic [31:0] s1 [8];

   peak_finder_mc_if #(.DATA_W(DW), .NUM_CH(NC), .IDX_W(IW)) bus ();

   peak_finder_mc #(.DATA_W(DW), .NUM_CH(NC), .EPOCH_LENGTH(EL)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] eidx(input int i);
      return IDX_ON ? 32'(i) : 32'd0;
   endfunction

   // feed samples s0/s1[first_i .. first_i+n-1], optionally with an idle cycle after each
   task automatic feed(input int first_i, input int n, input bit gap);
      for (int i = first_i; i < first_i + n; i++) begin
         bus.data_in  = {s1[i], s0[i]};
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         if (gap) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic chk_res(input string tag, input logic [31:0] v0, input int i0,
                          input logic [31:0] v1, input int i1);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_v0"}, bus.peak_value[31:0], v0);
      chk({tag, "_i0"}, 32'(bus.peak_idx[2:0]), eidx(i0));
      chk({tag, "_v1"}, bus.peak_value[63:32], v1);
      chk({tag, "_i1"}, 32'(bus.peak_idx[5:3]), eidx(i1));
   endtask

   initial begin
      bus.en = 1'b1; bus.mode = 2'b00; bus.in_valid = 1'b0;
      bus.data_in = '0; bus.out_ready = 1'b1;
      #12;
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_value", bus.peak_value[31:0] | bus.peak_value[63:32], 32'd0);
      chk("rst_idx", 32'(bus.peak_idx), 32'd0);
      chk("rst_overrun", 32'(bus.overrun), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // abs mode, tie keeps earliest index
      s0 = '{1, -9, 3, 9, 0, 0, 0, 0};
      s1 = '{5, 5, 5, 5, 5, 5, 5, 5};
      feed(0, 7, 1'b0);
      chk("abs_early", 32'(bus.out_valid), 32'd0);
      feed(7, 1, 1'b0);
      chk_res("abs", 32'd9, 1, 32'd5, 0);
      @(posedge clk); #1;
      chk("abs_drop", 32'(bus.out_valid), 32'd0);

      // max mode
      s0 = '{-3, -7, -1, -2, -8, -4, -6, -5};
      s1 = '{0, 0, 0, 0, 0, 0, 0, 0};
      bus.mode = 2'b01;
      feed(0, 8, 1'b0);
      chk_res("max", 32'hFFFF_FFFF, 2, 32'd0, 0);
      // min mode, mode changed mid-epoch must be ignored
      bus.mode = 2'b10;
      feed(0, 1, 1'b0);
      bus.mode = 2'b01;
      feed(1, 7, 1'b0);
      chk_res("min", 32'hFFFF_FFF8, 4, 32'd0, 0);

      // most negative input saturates; reserved mode behaves as abs
      s0 = '{32'h8000_0000, 0, 0, 0, 0, 0, 0, 0};
      s1 = '{7, -100, 50, 0, 0, 0, 0, 0};
      bus.mode = 2'b11;
      feed(0, 8, 1'b0);
      chk_res("sat", 32'h7FFF_FFFF, 0, 32'd100, 1);

      // 50% in_valid: gaps do not advance the index
      s0 = '{3, 1, 4, 1, 5, 9, 2, 6};
      s1 = '{0, 0, 0, 0, 0, 0, 0, 0};
      bus.mode = 2'b01;
      feed(0, 7, 1'b1);
      chk("gap_early", 32'(bus.out_valid), 32'd0);
      feed(7, 1, 1'b0);
      chk_res("gap", 32'd9, 5, 32'd0, 0);
      @(posedge clk); #1;

      // completion coinciding with accept: no overrun, last sample counted
      bus.out_ready = 1'b0;
      bus.mode = 2'b00;
      s0 = '{3, 3, 3, 3, 3, 3, 3, 3};
      s1 = '{-3, -3, -3, -3, -3, -3, -3, -3};
      feed(0, 8, 1'b0);
      chk_res("pend", 32'd3, 0, 32'd3, 0);
      s0 = '{0, 0, 0, 0, 0, 0, 0, -6};
      s1 = '{1, 1, 1, 1, 1, 1, 1, 1};
      feed(0, 7, 1'b0);
      bus.out_ready = 1'b1;
      feed(7, 1, 1'b0);
      chk_res("simul", 32'd6, 7, 32'd1, 0);
      chk("simul_overrun", 32'(bus.overrun), 32'd0);
      @(posedge clk); #1;
      chk("simul_drop", 32'(bus.out_valid), 32'd0);

      // overrun: two completions without acceptance
      bus.out_ready = 1'b0;
      s0 = '{1, 1, 1, 1, 1, 1, 1, 1};
      s1 = '{2, 2, 2, 2, 2, 2, 2, 2};
      feed(0, 8, 1'b0);
      chk_res("ovA", 32'd1, 0, 32'd2, 0);
      repeat (2) @(posedge clk);
      #1;
      chk_res("hold", 32'd1, 0, 32'd2, 0);
      chk("hold_overrun", 32'(bus.overrun), 32'd0);
      s0 = '{0, 0, 0, 7, 0, 0, 0, 0};
      s1 = '{0, 0, 0, 0, 0, 0, -4, 0};
      feed(0, 8, 1'b0);
      chk_res("ovB", 32'd7, 3, 32'd4, 6);
      chk("ovB_overrun", 32'(bus.overrun), 32'd1);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("ov_drop", 32'(bus.out_valid), 32'd0);
      chk("ov_sticky", 32'(bus.overrun), 32'd1);

      // en drop aborts the epoch
      bus.mode = 2'b01;
      bus.out_ready = 1'b0;
      s0 = '{100, 100, 100, 100, 100, 0, 0, 0};
      s1 = '{100, 100, 100, 100, 100, 0, 0, 0};
      feed(0, 5, 1'b0);
      bus.en = 1'b0;
      feed(0, 1, 1'b0);
      chk("abort_valid", 32'(bus.out_valid), 32'd0);
      bus.en = 1'b1;
      s0 = '{2, 8, 3, 8, 1, 0, 0, 0};
      s1 = '{-1, -2, -3, -4, -5, -6, -7, -8};
      feed(0, 7, 1'b0);
      chk("rearm_early", 32'(bus.out_valid), 32'd0);
      feed(7, 1, 1'b0);
      chk_res("rearm", 32'd8, 1, 32'hFFFF_FFFF, 0);

      // asynchronous reset with a pending result and a partial epoch
      feed(0, 3, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_value", bus.peak_value[31:0] | bus.peak_value[63:32], 32'd0);
      chk("arst_idx", 32'(bus.peak_idx), 32'd0);
      chk("arst_overrun", 32'(bus.overrun), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      s0 = '{4, 4, 4, 4, 4, 4, 4, 9};
      s1 = '{4, 4, 4, 4, 4, 4, 4, 4};
      feed(0, 7, 1'b0);
      chk("post_rst_early", 32'(bus.out_valid), 32'd0);
      feed(7, 1, 1'b0);
      chk_res("post_rst", 32'd9, 7, 32'd4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
